// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// 8 lines x (valid, 25-bit tag, 4 x 32-bit words). A hit returns the word
// combinationally in the same cycle. A miss stalls the fetch port, requests
// the whole 128-bit line from memory and refills on the mem_ready pulse.
// The cycle after a refill re-evaluates the same address as a hit.
module icache_dm (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    state_t        r_state;
    logic [7:0]    r_valid;
    logic [24:0]   r_tag  [8];
    logic [127:0]  r_data [8];
    logic [27:0]   r_miss_addr;
    logic          r_mem_read;

    logic [2:0]    w_idx;
    logic [24:0]   w_tag;
    logic [1:0]    w_word;
    logic          w_tag_match;
    logic          w_in_idle;
    logic          w_miss;
    logic          w_refill;
    logic [2:0]    w_miss_idx;
    logic [127:0]  w_line;

    // The block is read-only: write data and write requests are never used.
    logic          w_unused_ok;
    assign w_unused_ok = ^{proc_write, proc_wdata};

    assign w_idx       = proc_addr[4:2];
    assign w_tag       = proc_addr[29:5];
    assign w_word      = proc_addr[1:0];
    assign w_miss_idx  = r_miss_addr[2:0];
    assign w_in_idle   = (r_state == ST_IDLE);
    assign w_tag_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss      = w_in_idle && proc_read && !w_tag_match;
    // Reset has priority: a mem_ready coinciding with reset must not refill.
    assign w_refill    = !proc_reset && (r_state == ST_MISS) && mem_ready;
    assign w_line      = r_data[w_idx];

    // Stall on the miss-detect cycle and for the whole refill.
    assign proc_stall  = w_miss || (r_state == ST_MISS);
    assign mem_read    = r_mem_read;
    assign mem_addr    = r_miss_addr;
    assign mem_write   = 1'b0;
    assign mem_wdata   = 128'h0;

    // Select the addressed word of the indexed line for the fetch port.
    always_comb begin
        proc_rdata = 32'h0;
        case (w_word)
            2'd0:    proc_rdata = w_line[31:0];
            2'd1:    proc_rdata = w_line[63:32];
            2'd2:    proc_rdata = w_line[95:64];
            2'd3:    proc_rdata = w_line[127:96];
            default: proc_rdata = 32'h0;
        endcase
    end

    // Control FSM: miss detection, miss address capture, memory request, valid bits.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state     <= ST_IDLE;
            r_valid     <= 8'h00;
            r_miss_addr <= 28'h0;
            r_mem_read  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_state     <= ST_MISS;
                        r_miss_addr <= proc_addr[29:2];
                        r_mem_read  <= 1'b1;
                    end else begin
                        r_mem_read  <= 1'b0;
                    end
                end
                ST_MISS: begin
                    if (mem_ready) begin
                        r_state             <= ST_IDLE;
                        r_valid[w_miss_idx] <= 1'b1;
                        r_mem_read          <= 1'b0;
                    end else begin
                        r_mem_read          <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays: written only on refill, no reset needed.
    always_ff @(posedge clk) begin
        if (w_refill) begin
            r_tag[w_miss_idx]  <= r_miss_addr[27:3];
            r_data[w_miss_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized self-checking bench for icache_dm.
// The reference model is a plain valid/tag table plus a backing store of
// lines; it predicts hit/miss, stall length and the returned word.
module tb_icache_dm;

    logic         clk;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic [127:0] mem_wdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit           m_valid [8];
    logic [24:0]  m_tag   [8];
    logic [127:0] line_store [logic [27:0]];

    icache_dm dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] get_line(input logic [27:0] la);
        if (!line_store.exists(la))
            line_store[la] = {$urandom, $urandom, $urandom, $urandom};
        return line_store[la];
    endfunction

    // One fetch, starting and ending just after a rising edge.
    task automatic fetch(input logic [29:0] a, input int lat, output int stalls);
        logic [127:0] line;
        logic [31:0]  exp_data;
        logic [31:0]  got;
        bit           exp_hit;
        bit           done;
        int           mr;
        exp_hit  = m_valid[a[4:2]] && (m_tag[a[4:2]] == a[29:5]);
        line     = get_line(a[29:2]);
        exp_data = line[32*a[1:0] +: 32];
        proc_read  = 1'b1;
        proc_write = 1'b0;
        proc_addr  = a;
        mem_rdata  = line;
        mem_ready  = 1'b0;
        stalls = 0;
        mr     = 0;
        done   = 1'b0;
        got    = 32'h0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #4;
            if (!proc_stall) begin
                got  = proc_rdata;
                done = 1'b1;
                check("hit_mem_read", {127'h0, mem_read}, 128'h0);
            end else begin
                stalls++;
                if (mem_read) begin
                    mr++;
                    check("mem_addr", {100'h0, mem_addr}, {100'h0, a[29:2]});
                    if (mr == lat) mem_ready = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
        end
        if (!done) check("fetch_timeout", 128'h0, 128'h1);
        check("stall_cycles", stalls, exp_hit ? 0 : lat + 1);
        if (!exp_hit) check("mem_read_cycles", mr, lat);
        check("rdata", {96'h0, got}, {96'h0, exp_data});
        m_valid[a[4:2]] = 1'b1;
        m_tag[a[4:2]]   = a[29:5];
        proc_read = 1'b0;
    endtask

    function automatic logic [29:0] rand_addr();
        logic [24:0] t;
        logic [2:0]  ix;
        logic [1:0]  w;
        t  = 25'($urandom_range(0, 3));
        ix = 3'($urandom_range(0, 7));
        w  = 2'($urandom_range(0, 3));
        return {t, ix, w};
    endfunction

    initial begin
        int st;
        int sum;
        logic [29:0] a;
        logic [29:0] sweep [8];

        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = 30'h0;
        proc_wdata = 32'h0;
        mem_rdata  = 128'h0;
        mem_ready  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 25'h0;
        end
        line_store[28'h4] = 128'h44444444_33333333_22222222_11111111;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        proc_reset = 1'b0;
        #4;
        check("rst_mem_read", {127'h0, mem_read}, 128'h0);
        check("rst_mem_write", {127'h0, mem_write}, 128'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_stall_idle", {127'h0, proc_stall}, 128'h0);
        @(posedge clk);
        #1;

        // Cold miss with latency 4, then hit sweep within the line.
        fetch(30'h12, 4, st);
        fetch(30'h10, 1, st);
        fetch(30'h11, 1, st);
        fetch(30'h13, 1, st);

        // Conflict on index 4.
        fetch(30'h32, 3, st);
        fetch(30'h12, 2, st);

        // Write request with no read: no stall, no traffic, array unchanged.
        proc_write = 1'b1;
        proc_addr  = 30'h32;
        proc_wdata = $urandom;
        #4;
        check("wr_stall", {127'h0, proc_stall}, 128'h0);
        check("wr_mem_read", {127'h0, mem_read}, 128'h0);
        @(posedge clk);
        #1;
        proc_write = 1'b0;
        fetch(30'h11, 1, st);

        // Reset during MISS together with mem_ready: refill aborted.
        proc_read = 1'b1;
        proc_addr = 30'h2A5;
        mem_rdata = get_line(28'hA9);
        for (int cyc = 0; cyc < 8; cyc++) begin
            #4;
            if (mem_read) break;
            @(posedge clk);
            #1;
        end
        check("pre_rst_in_miss", {127'h0, mem_read}, 128'h1);
        proc_reset = 1'b1;
        mem_ready  = 1'b1;
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        mem_ready  = 1'b0;
        proc_read  = 1'b0;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        #4;
        check("rst_miss_mem_read", {127'h0, mem_read}, 128'h0);
        check("rst_miss_stall", {127'h0, proc_stall}, 128'h0);
        @(posedge clk);
        #1;
        fetch(30'h2A5, 2, st);

        // Index sweep: fill all 8 indices, then zero stalls on re-read.
        for (int i = 0; i < 8; i++) begin
            sweep[i] = {25'($urandom_range(4, 1000)), 3'(i), 2'($urandom_range(0, 3))};
            fetch(sweep[i], $urandom_range(1, 20), st);
        end
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            fetch({sweep[i][29:2], 2'($urandom_range(0, 3))}, 1, st);
            sum += st;
        end
        check("sweep_stalls", sum, 0);

        // Random traffic with random memory latency.
        for (int k = 0; k < 200; k++) begin
            a = rand_addr();
            if ($urandom_range(0, 4) == 0) begin
                proc_write = 1'b1;
                proc_addr  = a;
                proc_wdata = $urandom;
                #4;
                check("rnd_wr_stall", {127'h0, proc_stall}, 128'h0);
                @(posedge clk);
                #1;
                proc_write = 1'b0;
            end else begin
                fetch(a, $urandom_range(1, 20), st);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
